// File: rtl/param_priority_arbiter.sv
// N-channel arbiter with runtime fixed-priority / round-robin policy and
// bounded grant hold. Grant, grant_id and grant_valid are all registered.
module param_priority_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 4,
  parameter int IDW      = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid
);

  localparam int HW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  // With unlimited hold the counter only needs to show "holding"
  localparam int HOLD_SAT = (MAX_HOLD == 0) ? 1 : MAX_HOLD;

  logic [N-1:0]   grant_q;
  logic [IDW-1:0] grant_id_q;
  logic [IDW-1:0] last_q;
  logic [HW-1:0]  hold_cnt_q;

  logic           holder_req;
  logic           others;
  logic           expired;
  logic           keep;
  logic [N-1:0]   cand;
  logic [IDW-1:0] fixed_win;
  logic [IDW-1:0] rr_win;
  logic           rr_found;
  logic [IDW-1:0] rr_idx;
  logic [IDW-1:0] winner;

  always_comb begin
    holder_req = |(grant_q & req);
    others     = |(req & ~grant_q);
    expired    = (MAX_HOLD != 0) && (hold_cnt_q == HW'(HOLD_SAT));
    keep       = holder_req && (!expired || !others);
    cand       = (expired && others) ? (req & ~grant_q) : req;

    fixed_win = '0;
    for (int i = 0; i < N; i++) begin
      if (cand[i]) fixed_win = IDW'(i);
    end

    // Round-robin search starts just after the most recent winner and wraps
    rr_win   = '0;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < N; k++) begin
      rr_idx = IDW'((int'(last_q) + 1 + k) % N);
      if (!rr_found && cand[rr_idx]) begin
        rr_found = 1'b1;
        rr_win   = rr_idx;
      end
    end

    winner = mode ? rr_win : fixed_win;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= IDW'(N - 1);
      hold_cnt_q <= '0;
    end else if (keep) begin
      if (hold_cnt_q != HW'(HOLD_SAT)) hold_cnt_q <= hold_cnt_q + HW'(1);
    end else if (|req) begin
      grant_q    <= {{(N-1){1'b0}}, 1'b1} << winner;
      grant_id_q <= winner;
      last_q     <= winner;
      hold_cnt_q <= HW'(1);
    end else begin
      grant_q    <= '0;
      hold_cnt_q <= '0;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = grant_id_q;
  assign grant_valid = |grant_q;

endmodule

// File: tb/tb_param_priority_arbiter.sv
// Directed bench for param_priority_arbiter with N=4, MAX_HOLD=3:
// a vector table for the main sequences plus hand-written corner cases.
module tb_param_priority_arbiter;

  localparam int N        = 4;
  localparam int MAX_HOLD = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst;
    logic       mode;
    logic [3:0] req;
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
  } vec_t;

  vec_t vq[$];

  param_priority_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst(rst),
    .mode(mode),
    .req(req),
    .grant(grant),
    .grant_id(grant_id),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic m, logic [3:0] rq,
                              logic [3:0] g, logic [1:0] id, logic v);
    vec_t t;
    t.rst = r; t.mode = m; t.req = rq; t.g = g; t.id = id; t.v = v;
    return t;
  endfunction

  task automatic check(string name, logic [3:0] g, logic [1:0] id, logic v);
    checks++;
    if (grant !== g || grant_id !== id || grant_valid !== v) begin
      errors++;
      $display("FAIL %s: got grant=%b id=%0d valid=%b, want grant=%b id=%0d valid=%b",
               name, grant, grant_id, grant_valid, g, id, v);
    end
  endtask

  // Inputs change on the falling edge, outputs are sampled on the next one.
  task automatic step(logic r, logic m, logic [3:0] rq);
    rst = r; mode = m; req = rq;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; req = 4'b0000;

    // Reset held with all requesting, then release in fixed mode
    vq.push_back(mk(1, 0, 4'b1111, 4'b0000, 2'd0, 0));
    vq.push_back(mk(1, 0, 4'b1111, 4'b0000, 2'd0, 0));
    vq.push_back(mk(0, 0, 4'b1111, 4'b1000, 2'd3, 1));
    vq.push_back(mk(1, 0, 4'b0000, 4'b0000, 2'd0, 0));
    // Fixed priority, req=1010: 1000 x3, 0010 x3, 1000
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 4'b1010, 4'b1000, 2'd3, 1));
    for (int i = 0; i < 3; i++) vq.push_back(mk(0, 0, 4'b1010, 4'b0010, 2'd1, 1));
    vq.push_back(mk(0, 0, 4'b1010, 4'b1000, 2'd3, 1));
    vq.push_back(mk(1, 0, 4'b1010, 4'b0000, 2'd0, 0));
    // Round-robin rotation from reset
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 3; i++)
        vq.push_back(mk(0, 1, 4'b1111, 4'b0001 << c, 2'(c), 1));
    vq.push_back(mk(0, 1, 4'b1111, 4'b0001, 2'd0, 1));
    // Holder drops, ch2 alone, then 0100 -> 1001 in one cycle, then idle
    vq.push_back(mk(0, 1, 4'b0100, 4'b0100, 2'd2, 1));
    vq.push_back(mk(0, 1, 4'b1001, 4'b1000, 2'd3, 1));
    vq.push_back(mk(0, 1, 4'b0000, 4'b0000, 2'd3, 0));
    vq.push_back(mk(0, 1, 4'b0000, 4'b0000, 2'd3, 0));

    @(negedge clk);
    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].mode, vq[i].req);
      check($sformatf("vec%0d", i), vq[i].g, vq[i].id, vq[i].v);
    end

    // Mode switch mid-hold: ch1 granted alone in fixed mode, then rr with 0110
    step(1, 0, 4'b0000);
    check("ms_reset", 4'b0000, 2'd0, 0);
    step(0, 0, 4'b0010);
    check("ms_grant1", 4'b0010, 2'd1, 1);
    step(0, 1, 4'b0110);
    check("ms_keep_h2", 4'b0010, 2'd1, 1);
    step(0, 1, 4'b0110);
    check("ms_keep_h3", 4'b0010, 2'd1, 1);
    step(0, 1, 4'b0110);
    check("ms_switch", 4'b0100, 2'd2, 1);

    // Mid-operation reset while ch2 holds in round-robin
    step(1, 1, 4'b1111);
    for (int i = 0; i < 7; i++) step(0, 1, 4'b1111);
    check("mr_ch2_holds", 4'b0100, 2'd2, 1);
    step(1, 1, 4'b1111);
    check("mr_reset", 4'b0000, 2'd0, 0);
    step(0, 1, 4'b1111);
    check("mr_after", 4'b0001, 2'd0, 1);

    // Single requester keeps the grant past MAX_HOLD
    step(0, 1, 4'b0100);
    check("single_first", 4'b0100, 2'd2, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 4'b0100);
      check($sformatf("single_hold%0d", i), 4'b0100, 2'd2, 1);
    end

    // Fixed mode with everyone requesting: top two alternate
    step(1, 0, 4'b1111);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        step(0, 0, 4'b1111);
        check("fx_top", 4'b1000, 2'd3, 1);
      end
      for (int i = 0; i < 3; i++) begin
        step(0, 0, 4'b1111);
        check("fx_second", 4'b0100, 2'd2, 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/param_priority_arbiter.md
# param_priority_arbiter

Parametrised N-channel arbiter. It is the successor to the team's fixed 4-way priority arbiter and sits in front of shared resources such as the UART TX path and bus slaves. It adds a runtime-selectable fixed-priority or round-robin policy and grant locking with a bounded hold time. Outputs are a registered one-hot grant plus a binary grant index and a valid flag.

## Interface
- `N`, default 4: number of requesters; legal range is 2..32.
- `MAX_HOLD`, default 4: maximum consecutive cycles a holder keeps the grant while other channels request; 0 means unlimited.
- `IDW`, default `$clog2(N)`: width of `grant_id`; derived, do not override.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `mode`, input, 1: arbitration policy; 0 = fixed priority (highest index wins), 1 = round-robin.
- `req`, input, N: request lines, level-sensitive; bit i belongs to channel i.
- `grant`, output, N: registered one-hot grant, or all zeros.
- `grant_id`, output, IDW: binary index of the granted channel; holds its last value when idle.
- `grant_valid`, output, 1: high when `grant` is non-zero.

## Operation
- Internal state:
  - `grant` register.
  - `last`: index of the most recent new grant.
  - `hold_cnt`: cycles the current holder has held the grant. Width is `$clog2(MAX_HOLD+1)`, minimum 1. It saturates at `MAX_HOLD`.
- Every cycle exactly one of three decisions is made and registered on the next edge.
- KEEP applies when all of the following are true:
  - The current holder's `req` bit is still 1.
  - Either `MAX_HOLD`==0, or `hold_cnt` < `MAX_HOLD`, or no other channel is requesting.
  - Result: `grant` is unchanged and `hold_cnt` increments, saturating.
- ARBITRATE applies otherwise, whenever `req` is non-zero.
  - Candidate set is `req`. The holder is masked out when its hold has expired and another channel requests.
  - Fixed mode: the highest-index candidate wins.
  - Round-robin mode: search starts at index (`last`+1) mod N, ascending, and wraps; the first candidate wins.
  - Winner updates: `grant` is set to one-hot(winner), `grant_id` to winner, `last` to winner, `hold_cnt` to 1.
- IDLE applies when `req` is all zeros.
  - `grant` goes to 0 and `grant_valid` to 0.
  - `hold_cnt` goes to 0.
  - `last` and `grant_id` are unchanged.
- A holder that drops `req` is replaced on the same edge if others are requesting; there is no idle bubble.
- A `mode` change never preempts a holder. It takes effect at the next ARBITRATE decision.
- `last` updates in both modes, so switching to round-robin continues fairly from the most recent winner.
- Invariants:
  - `grant` is always zero or one-hot.
  - `grant` is only set for a channel whose `req` was 1 in the cycle before.

## Timing
- Reset values: `grant`=0, `grant_id`=0, `grant_valid`=0, `hold_cnt`=0, `last`=N-1. The first round-robin search therefore starts at channel 0.
- Reset is sampled on the clock edge and overrides all other activity, including mid-hold. On the first edge after `rst` falls, arbitration runs from the reset state.
- Latency: 1 cycle from `req` to `grant`. `grant`, `grant_id` and `grant_valid` change together on the same edge.
- Release: the holder deasserts `req` in cycle t; `grant` is updated at the edge ending cycle t.
- Bounded wait when all channels request continuously with `MAX_HOLD`>0:
  - Round-robin mode: each channel is granted within (N-1)·`MAX_HOLD`+1 cycles.
  - Fixed mode: only the top two requesting channels alternate. Starvation of lower channels is by design.
- With `MAX_HOLD`=0, the holder keeps the grant until it drops `req`, in both modes.
- Single requester: it keeps the grant indefinitely; `hold_cnt` saturates with no re-arbitration.

## Test plan
All scenarios use N=4 and `MAX_HOLD`=3.
- Reset: assert `rst` for 2 cycles with `req`=1111. Required: `grant`=0000, `grant_valid`=0, `grant_id`=0 throughout; the first edge after release gives `grant`=1000 in fixed mode.
- Fixed priority with hold: `mode`=0, `req`=1010 held constant. Required: `grant` is 1000 for 3 cycles, then 0010 for 3 cycles, then 1000, repeating; `grant_valid` stays 1.
- Round-robin rotation: `mode`=1, `req`=1111 from reset. Required: 0001 ×3, 0010 ×3, 0100 ×3, 1000 ×3, then 0001 again; `grant_id` steps 0, 1, 2, 3, 0.
- Release without bubble: `mode`=1, channel 2 holds; `req` changes from 0100 to 1001 in one cycle. Required: next `grant`=1000 (search starts at index 3), `grant_valid` never drops; `req`=0000 then gives `grant`=0000 and `grant_id` stays 3.
- Mode switch mid-hold: channel 1 holds in fixed mode with `req`=0110; set `mode`=1 at `hold_cnt`=1. Required: channel 1 keeps the grant until `hold_cnt` reaches 3, then `grant`=0100.
- Mid-operation reset: `req`=1111 in round-robin mode with channel 2 holding; assert `rst` for 1 cycle. Required: `grant`=0000 on that edge, then `grant`=0001 on the first edge after release.
